hazard5_bus_arbiter: RTL and testbench

- Shares the core's single AHB-Lite master port between two requesters: instruction fetch (frontend) and load/store (LSU).
- Grants address phases by fixed priority (LSU over fetch), with a starvation guard that periodically forces a fetch grant.
- Tracks data-phase ownership and routes hready, hrdata and error responses back to the owning requester.
- Sits between the frontend/LSU and the system bus; no buffering of data.

---
 rtl/hazard5_bus_arbiter_pkg.sv | 28 ++
 rtl/hazard5_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_hazard5_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard5_bus_arbiter_pkg.sv
// Shared AHB-Lite encodings and requester ownership type for the Hazard5 bus arbiter.
package hazard5_bus_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [3:0] HPROT_FETCH = 4'b0010;
  localparam logic [3:0] HPROT_DATA  = 4'b0011;

  // Who owns an address or data phase on the shared master port
  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_LSU   = 2'd2
  } owner_t;

  // Fetch only ever issues word or halfword transfers
  function automatic logic [2:0] fetch_hsize(input logic f_size);
    return f_size ? HSIZE_WORD : HSIZE_HALF;
  endfunction

endpackage

// File: rtl/hazard5_bus_arbiter.sv
// Two-requester AHB-Lite arbiter: LSU has priority over instruction fetch, a
// starvation counter periodically forces a fetch grant, and data-phase
// responses are steered back to whichever requester owns the data phase.
module hazard5_bus_arbiter
  import hazard5_bus_arbiter_pkg::*;
#(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  output logic [W_ADDR-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata,

  input  logic [W_ADDR-1:0] f_addr,
  input  logic              f_size,
  input  logic              f_addr_vld,
  output logic              f_addr_rdy,
  output logic [W_DATA-1:0] f_data,
  output logic              f_data_vld,
  output logic              f_data_err,

  input  logic [W_ADDR-1:0] l_addr,
  input  logic              l_write,
  input  logic [1:0]        l_size,
  input  logic              l_addr_vld,
  output logic              l_addr_rdy,
  input  logic [W_DATA-1:0] l_wdata,
  output logic [W_DATA-1:0] l_rdata,
  output logic              l_data_vld,
  output logic              l_data_err
);

  // A zero limit disables the guard, but the counter still needs one bit to exist
  localparam int W_CTR = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [W_CTR-1:0] CTR_LIMIT = W_CTR'(STARVE_LIMIT);

  logic             aph_hold_q,  aph_hold_d;
  owner_t           aph_owner_q, aph_owner_d;
  owner_t           dph_owner_q, dph_owner_d;
  logic [W_CTR-1:0] starve_ctr_q, starve_ctr_d;

  owner_t grant;
  logic   force_f;

  // State registers; reset discards any in-flight ownership so the slave sees IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph_hold_q   <= 1'b0;
      aph_owner_q  <= OWNER_NONE;
      dph_owner_q  <= OWNER_NONE;
      starve_ctr_q <= '0;
    end else begin
      aph_hold_q   <= aph_hold_d;
      aph_owner_q  <= aph_owner_d;
      dph_owner_q  <= dph_owner_d;
      starve_ctr_q <= starve_ctr_d;
    end
  end

  // Grant selection: a stalled address phase keeps its owner, otherwise LSU wins unless fetch is starving
  always_comb begin
    force_f = (STARVE_LIMIT != 0) && (starve_ctr_q == CTR_LIMIT) && f_addr_vld;
    grant   = OWNER_NONE;
    if (aph_hold_q) begin
      grant = aph_owner_q;
    end else if (l_addr_vld && !force_f) begin
      grant = OWNER_LSU;
    end else if (f_addr_vld) begin
      grant = OWNER_FETCH;
    end
  end

  // Address-phase mux onto the shared master port
  always_comb begin
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    hprot  = HPROT_FETCH;
    case (grant)
      OWNER_LSU: begin
        htrans = HTRANS_NONSEQ;
        haddr  = l_addr;
        hwrite = l_write;
        hsize  = {1'b0, l_size};
        hprot  = HPROT_DATA;
      end
      OWNER_FETCH: begin
        htrans = HTRANS_NONSEQ;
        haddr  = f_addr;
        hwrite = 1'b0;
        hsize  = fetch_hsize(f_size);
        hprot  = HPROT_FETCH;
      end
      default: begin
        htrans = HTRANS_IDLE;
      end
    endcase
  end

  // Next-state: hold the address phase over wait states, advance the data phase only on hready
  always_comb begin
    aph_hold_d   = (htrans == HTRANS_NONSEQ) && !hready;
    aph_owner_d  = grant;
    dph_owner_d  = hready ? grant : dph_owner_q;
    starve_ctr_d = starve_ctr_q;
    if (!f_addr_vld || f_addr_rdy) begin
      starve_ctr_d = '0;
    end else if (l_addr_rdy && (starve_ctr_q != CTR_LIMIT)) begin
      starve_ctr_d = starve_ctr_q + 1'b1;
    end
  end

  // Requester handshakes and response steering back to the data-phase owner
  always_comb begin
    f_addr_rdy = hready && (grant == OWNER_FETCH);
    l_addr_rdy = hready && (grant == OWNER_LSU);
    f_data_vld = hready && !hresp && (dph_owner_q == OWNER_FETCH);
    f_data_err = hready &&  hresp && (dph_owner_q == OWNER_FETCH);
    l_data_vld = hready && !hresp && (dph_owner_q == OWNER_LSU);
    l_data_err = hready &&  hresp && (dph_owner_q == OWNER_LSU);
    f_data     = hrdata;
    l_rdata    = hrdata;
    hwdata     = (dph_owner_q == OWNER_LSU) ? l_wdata : '0;
    hburst     = HBURST_SINGLE;
    hmastlock  = 1'b0;
  end

endmodule

// File: tb/tb_hazard5_bus_arbiter.sv
// Directed bench for the Hazard5 bus arbiter: priority, stalls, starvation guard, errors and reset.
module tb_hazard5_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic        hready;
  logic        hresp;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic [31:0] f_addr;
  logic        f_size;
  logic        f_addr_vld;
  logic        f_addr_rdy;
  logic [31:0] f_data;
  logic        f_data_vld;
  logic        f_data_err;
  logic [31:0] l_addr;
  logic        l_write;
  logic [1:0]  l_size;
  logic        l_addr_vld;
  logic        l_addr_rdy;
  logic [31:0] l_wdata;
  logic [31:0] l_rdata;
  logic        l_data_vld;
  logic        l_data_err;

  int passed = 0;
  int total  = 0;

  // Expected address sequence with LSU and fetch both requesting continuously
  logic [31:0] starve_addr [6] = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h0400, 32'h4000};
  logic        starve_frdy [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  hazard5_bus_arbiter #(
    .W_ADDR(32),
    .W_DATA(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .haddr(haddr),
    .hwrite(hwrite),
    .htrans(htrans),
    .hsize(hsize),
    .hburst(hburst),
    .hprot(hprot),
    .hmastlock(hmastlock),
    .hready(hready),
    .hresp(hresp),
    .hwdata(hwdata),
    .hrdata(hrdata),
    .f_addr(f_addr),
    .f_size(f_size),
    .f_addr_vld(f_addr_vld),
    .f_addr_rdy(f_addr_rdy),
    .f_data(f_data),
    .f_data_vld(f_data_vld),
    .f_data_err(f_data_err),
    .l_addr(l_addr),
    .l_write(l_write),
    .l_size(l_size),
    .l_addr_vld(l_addr_vld),
    .l_addr_rdy(l_addr_rdy),
    .l_wdata(l_wdata),
    .l_rdata(l_rdata),
    .l_data_vld(l_data_vld),
    .l_data_err(l_data_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle, drive all inputs just after the edge, then let combinational outputs settle
  task automatic applyStimulus(
    input logic        fv, input logic [31:0] fa, input logic fs,
    input logic        lv, input logic [31:0] la, input logic lw, input logic [1:0] ls,
    input logic [31:0] wd, input logic rdy, input logic resp, input logic [31:0] rdata
  );
    @(posedge clk);
    #1;
    f_addr_vld = fv;
    f_addr     = fa;
    f_size     = fs;
    l_addr_vld = lv;
    l_addr     = la;
    l_write    = lw;
    l_size     = ls;
    l_wdata    = wd;
    hready     = rdy;
    hresp      = resp;
    hrdata     = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    rst_n      = 1'b0;
    f_addr_vld = 1'b0;
    f_addr     = '0;
    f_size     = 1'b1;
    l_addr_vld = 1'b0;
    l_addr     = '0;
    l_write    = 1'b0;
    l_size     = 2'd0;
    l_wdata    = '0;
    hready     = 1'b1;
    hresp      = 1'b0;
    hrdata     = '0;
    #1;
    checkOutput("reset_htrans",   32'(htrans),     32'(2'b00));
    checkOutput("reset_haddr",    haddr,           32'h0);
    checkOutput("reset_hsize",    32'(hsize),      32'(3'b010));
    checkOutput("reset_frdy",     32'(f_addr_rdy), 32'd0);
    checkOutput("reset_fvld",     32'(f_data_vld), 32'd0);
    checkOutput("reset_lvld",     32'(l_data_vld), 32'd0);
    checkOutput("reset_hburst",   32'(hburst),     32'd0);
    checkOutput("reset_hmastlock",32'(hmastlock),  32'd0);
    #1;
    rst_n = 1'b1;
    $display("[TB] fetch-only back-to-back");

    applyStimulus(1, 32'h100, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("f1_htrans", 32'(htrans),     32'(2'b10));
    checkOutput("f1_haddr",  haddr,           32'h100);
    checkOutput("f1_hsize",  32'(hsize),      32'(3'b010));
    checkOutput("f1_hprot",  32'(hprot),      32'(4'b0010));
    checkOutput("f1_frdy",   32'(f_addr_rdy), 32'd1);
    checkOutput("f1_fvld",   32'(f_data_vld), 32'd0);

    applyStimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1111_1111);
    checkOutput("f2_haddr",  haddr,           32'h104);
    checkOutput("f2_hsize",  32'(hsize),      32'(3'b001));
    checkOutput("f2_fvld",   32'(f_data_vld), 32'd1);
    checkOutput("f2_fdata",  f_data,          32'h1111_1111);
    checkOutput("f2_lvld",   32'(l_data_vld), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h2222_2222);
    checkOutput("f3_fvld",   32'(f_data_vld), 32'd1);
    checkOutput("f3_fdata",  f_data,          32'h2222_2222);
    checkOutput("f3_htrans", 32'(htrans),     32'(2'b00));

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("f4_fvld",   32'(f_data_vld), 32'd0);
    checkOutput("f4_haddr",  haddr,           32'h0);
    $display("[TB] simultaneous requests");

    applyStimulus(1, 32'h200, 1, 1, 32'h2000, 1, 2'd2, 32'hDEAD_BEEF, 1, 0, 0);
    checkOutput("s1_haddr",  haddr,           32'h2000);
    checkOutput("s1_hwrite", 32'(hwrite),     32'd1);
    checkOutput("s1_hprot",  32'(hprot),      32'(4'b0011));
    checkOutput("s1_lrdy",   32'(l_addr_rdy), 32'd1);
    checkOutput("s1_frdy",   32'(f_addr_rdy), 32'd0);

    applyStimulus(1, 32'h200, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 0);
    checkOutput("s2_haddr",  haddr,           32'h200);
    checkOutput("s2_frdy",   32'(f_addr_rdy), 32'd1);
    checkOutput("s2_hwrite", 32'(hwrite),     32'd0);
    checkOutput("s2_hwdata", hwdata,          32'hDEAD_BEEF);
    checkOutput("s2_lvld",   32'(l_data_vld), 32'd1);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 32'h3333_3333);
    checkOutput("s3_hwdata", hwdata,          32'h0);
    checkOutput("s3_fvld",   32'(f_data_vld), 32'd1);
    checkOutput("s3_htrans", 32'(htrans),     32'(2'b00));
    $display("[TB] fetch stall with late LSU request");

    applyStimulus(1, 32'h300, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("w1_haddr",  haddr,           32'h300);
    checkOutput("w1_htrans", 32'(htrans),     32'(2'b10));
    checkOutput("w1_frdy",   32'(f_addr_rdy), 32'd0);

    applyStimulus(1, 32'h300, 1, 1, 32'h3000, 0, 2'd1, 0, 0, 0, 0);
    checkOutput("w2_haddr",  haddr,           32'h300);
    checkOutput("w2_lrdy",   32'(l_addr_rdy), 32'd0);
    checkOutput("w2_hprot",  32'(hprot),      32'(4'b0010));

    applyStimulus(1, 32'h300, 1, 1, 32'h3000, 0, 2'd1, 0, 0, 0, 0);
    checkOutput("w3_haddr",  haddr,           32'h300);

    applyStimulus(1, 32'h300, 1, 1, 32'h3000, 0, 2'd1, 0, 1, 0, 0);
    checkOutput("w4_haddr",  haddr,           32'h300);
    checkOutput("w4_frdy",   32'(f_addr_rdy), 32'd1);
    checkOutput("w4_lrdy",   32'(l_addr_rdy), 32'd0);
    checkOutput("w4_fvld",   32'(f_data_vld), 32'd0);

    applyStimulus(0, 0, 1, 1, 32'h3000, 0, 2'd1, 0, 1, 0, 32'h4444_4444);
    checkOutput("w5_haddr",  haddr,           32'h3000);
    checkOutput("w5_hsize",  32'(hsize),      32'(3'b001));
    checkOutput("w5_lrdy",   32'(l_addr_rdy), 32'd1);
    checkOutput("w5_fvld",   32'(f_data_vld), 32'd1);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h5555_5555);
    checkOutput("w6_lvld",   32'(l_data_vld), 32'd1);
    checkOutput("w6_lrdata", l_rdata,         32'h5555_5555);
    checkOutput("w6_htrans", 32'(htrans),     32'(2'b00));
    $display("[TB] starvation guard");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'h400, 1, 1, 32'h4000, 0, 2'd2, 0, 1, 0, 0);
      checkOutput($sformatf("st%0d_haddr", i), haddr, starve_addr[i]);
      checkOutput($sformatf("st%0d_frdy", i), 32'(f_addr_rdy), 32'(starve_frdy[i]));
    end

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("st_end_lvld",   32'(l_data_vld), 32'd1);
    checkOutput("st_end_htrans", 32'(htrans),     32'(2'b00));
    $display("[TB] LSU error response");

    applyStimulus(0, 0, 1, 1, 32'h5000, 0, 2'd0, 0, 1, 0, 0);
    checkOutput("e1_lrdy",   32'(l_addr_rdy), 32'd1);
    checkOutput("e1_hsize",  32'(hsize),      32'(3'b000));

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("e2_lerr",   32'(l_data_err), 32'd0);
    checkOutput("e2_lvld",   32'(l_data_vld), 32'd0);
    checkOutput("e2_ferr",   32'(f_data_err), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("e3_lerr",   32'(l_data_err), 32'd1);
    checkOutput("e3_lvld",   32'(l_data_vld), 32'd0);
    checkOutput("e3_fvld",   32'(f_data_vld), 32'd0);
    checkOutput("e3_ferr",   32'(f_data_err), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("e4_lerr",   32'(l_data_err), 32'd0);
    $display("[TB] reset during LSU data phase");

    applyStimulus(0, 0, 1, 1, 32'h6000, 1, 2'd2, 32'hCAFE_F00D, 1, 0, 0);
    checkOutput("r1_lrdy",   32'(l_addr_rdy), 32'd1);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 0);
    checkOutput("r2_hwdata", hwdata,          32'hCAFE_F00D);
    checkOutput("r2_lvld",   32'(l_data_vld), 32'd0);

    rst_n = 1'b0;
    #1;
    checkOutput("r3_htrans", 32'(htrans),     32'(2'b00));
    checkOutput("r3_hwdata", hwdata,          32'h0);
    checkOutput("r3_lerr",   32'(l_data_err), 32'd0);
    hready = 1'b1;
    #1;
    checkOutput("r4_lvld",   32'(l_data_vld), 32'd0);
    checkOutput("r4_fvld",   32'(f_data_vld), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;

    applyStimulus(1, 32'h700, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("r5_haddr",  haddr,           32'h700);
    checkOutput("r5_frdy",   32'(f_addr_rdy), 32'd1);
    checkOutput("r5_lvld",   32'(l_data_vld), 32'd0);

    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h77);
    checkOutput("r6_fvld",   32'(f_data_vld), 32'd1);
    checkOutput("r6_fdata",  f_data,          32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
